// File: rtl/counter_pkg.sv
// Shared constants and type definitions for the counter/address generator.
package counter_pkg;

    // Manual opcodes, decoded only while the FSM is idle.
    localparam logic [2:0] OPC_CLEAR = 3'b000;
    localparam logic [2:0] OPC_HOLD  = 3'b001;
    localparam logic [2:0] OPC_INC   = 3'b010;
    localparam logic [2:0] OPC_DEC   = 3'b011;
    localparam logic [2:0] OPC_LOAD  = 3'b100;

    // Burst controller states.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Operation requested from the shared next-address datapath.
    typedef enum logic [2:0] {
        STEP_HOLD  = 3'd0,
        STEP_CLEAR = 3'd1,
        STEP_INC   = 3'd2,
        STEP_DEC   = 3'd3,
        STEP_LOAD  = 3'd4
    } step_op_e;

endpackage

// File: rtl/addr_step.sv
// Combinational next-address datapath: increment/decrement with wrap or
// saturate at Last, clear, hold, and clamped load. Shared by the manual
// opcode path and the burst path.
module addr_step
    import counter_pkg::*;
#(
    parameter int Width = 5,
    parameter int Last  = 31,
    parameter int Wrap  = 1
) (
    input  step_op_e             op,
    input  logic     [Width-1:0] cur,
    input  logic     [Width-1:0] load_val,
    output logic     [Width-1:0] nxt,
    output logic                 wrapped
);

    localparam logic [Width-1:0] LAST_W = Width'(Last);
    localparam logic [Width-1:0] ONE_W  = Width'(1);

    // Compute the next address; the boundary test is an explicit compare
    // against Last so a non-power-of-two terminal address behaves correctly.
    always_comb begin
        // NOTE: every output gets a default before the case so no path can
        // leave it unassigned and infer a latch.
        nxt     = cur;
        wrapped = 1'b0;
        case (op)
            STEP_CLEAR: nxt = '0;
            STEP_INC: begin
                if (cur == LAST_W) begin
                    if (Wrap != 0) begin
                        nxt     = '0;
                        wrapped = 1'b1;
                    end else begin
                        nxt = LAST_W;
                    end
                end else begin
                    nxt = cur + ONE_W;
                end
            end
            STEP_DEC: begin
                if (cur == '0) begin
                    if (Wrap != 0) begin
                        nxt     = LAST_W;
                        wrapped = 1'b1;
                    end else begin
                        nxt = '0;
                    end
                end else begin
                    nxt = cur - ONE_W;
                end
            end
            STEP_LOAD: nxt = (load_val > LAST_W) ? LAST_W : load_val;
            default:   nxt = cur;
        endcase
    end

endmodule

// File: rtl/counter_address_gen.sv
// Counter / address generator with a manual opcode mode (IDLE) and an
// auto-incrementing burst mode (RUN) of len_i+1 addresses.
module counter_address_gen
    import counter_pkg::*;
#(
    parameter int Width = 5,
    parameter int Last  = 31,
    parameter int Wrap  = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [2:0]       opc_i,
    input  logic [Width-1:0] load_i,
    input  logic             start_i,
    input  logic [Width-1:0] len_i,
    output logic [Width-1:0] count_o,
    output logic             flag_o,
    output logic             zero_o,
    output logic             wrap_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam logic [Width-1:0] LAST_W = Width'(Last);
    localparam logic [Width-1:0] ONE_W  = Width'(1);

    state_e           state_q, state_d;
    logic [Width-1:0] count_q, count_d;
    logic [Width-1:0] beats_q, beats_d;
    logic             wrap_q, wrap_d;
    logic             done_q, done_d;

    step_op_e         step_op;
    logic [Width-1:0] step_nxt;
    logic             step_wrapped;

    addr_step #(
        .Width (Width),
        .Last  (Last),
        .Wrap  (Wrap)
    ) u_addr_step (
        .op       (step_op),
        .cur      (count_q),
        .load_val (load_i),
        .nxt      (step_nxt),
        .wrapped  (step_wrapped)
    );

    // Next-state and datapath control: start beats opcodes in IDLE; in RUN
    // only a clear opcode (abort) is honoured, and it wins over completion.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        beats_d = beats_q;
        wrap_d  = 1'b0;
        done_d  = 1'b0;
        step_op = STEP_HOLD;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    step_op = STEP_LOAD;
                    count_d = step_nxt;
                    beats_d = len_i;
                    state_d = ST_RUN;
                end else begin
                    case (opc_i)
                        OPC_HOLD: step_op = STEP_HOLD;
                        OPC_INC:  step_op = STEP_INC;
                        OPC_DEC:  step_op = STEP_DEC;
                        OPC_LOAD: step_op = STEP_LOAD;
                        default:  step_op = STEP_CLEAR;
                    endcase
                    count_d = step_nxt;
                    wrap_d  = step_wrapped;
                end
            end
            ST_RUN: begin
                if (opc_i == OPC_CLEAR) begin
                    count_d = '0;
                    beats_d = '0;
                    state_d = ST_IDLE;
                end else if (beats_q == '0) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    step_op = STEP_INC;
                    count_d = step_nxt;
                    wrap_d  = step_wrapped;
                    beats_d = beats_q - ONE_W;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, address, beat counter and event pulses; reset is asynchronous so
    // a mid-burst reset clears everything without waiting for a clock edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: registers use non-blocking assignments so every flop samples
        // the pre-edge values of the others, independent of statement order.
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            beats_q <= '0;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            beats_q <= beats_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
        end
    end

    assign count_o = count_q;
    assign flag_o  = (count_q == LAST_W);
    assign zero_o  = (count_q == '0);
    assign wrap_o  = wrap_q;
    assign done_o  = done_q;
    assign busy_o  = (state_q == ST_RUN);

endmodule

// File: tb/tb_counter_address_gen.sv
// Self-checking bench: two instances (wrap Last=31, saturate Last=20) share
// one stimulus stream; a behavioural model is compared every cycle, and
// directed sequences pin key values with literal expectations.
module tb_counter_address_gen;

    logic       clk;
    logic       rst_n;
    logic [2:0] opc;
    logic [4:0] load;
    logic       start;
    logic [4:0] len;

    logic [4:0] cnt_a, cnt_b;
    logic       flag_a, zero_a, wrap_a, busy_a, done_a;
    logic       flag_b, zero_b, wrap_b, busy_b, done_b;

    int n_checks = 0;
    int n_errors = 0;

    counter_address_gen #(.Width(5), .Last(31), .Wrap(1)) dut_a (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .opc_i   (opc),
        .load_i  (load),
        .start_i (start),
        .len_i   (len),
        .count_o (cnt_a),
        .flag_o  (flag_a),
        .zero_o  (zero_a),
        .wrap_o  (wrap_a),
        .busy_o  (busy_a),
        .done_o  (done_a)
    );

    counter_address_gen #(.Width(5), .Last(20), .Wrap(0)) dut_b (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .opc_i   (opc),
        .load_i  (load),
        .start_i (start),
        .len_i   (len),
        .count_o (cnt_b),
        .flag_o  (flag_b),
        .zero_o  (zero_b),
        .wrap_o  (wrap_b),
        .busy_o  (busy_b),
        .done_o  (done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, actual, actual, expected, expected, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int count;
        int beats;
        bit run;
        bit wr;
        bit dn;
    } mdl_t;

    mdl_t m_a, m_b;

    function automatic mdl_t mdl_reset();
        mdl_t r;
        r.count = 0; r.beats = 0; r.run = 0; r.wr = 0; r.dn = 0;
        return r;
    endfunction

    function automatic int min_i(int x, int y);
        return (x < y) ? x : y;
    endfunction

    // Apply one clock edge's worth of behaviour described by the block's rules.
    function automatic mdl_t mdl_next(mdl_t m, int last, bit wrap_en,
                                      int op, int ld, bit st, int ln);
        mdl_t r = m;
        r.wr = 0;
        r.dn = 0;
        if (!m.run) begin
            if (st) begin
                r.count = min_i(ld, last);
                r.beats = ln;
                r.run   = 1;
            end else begin
                case (op)
                    1: r.count = m.count;
                    2: begin
                        if (wrap_en) begin
                            r.count = (m.count + 1) % (last + 1);
                            r.wr    = (m.count == last);
                        end else r.count = min_i(m.count + 1, last);
                    end
                    3: begin
                        if (wrap_en) begin
                            r.count = (m.count + last) % (last + 1);
                            r.wr    = (m.count == 0);
                        end else r.count = (m.count > 0) ? m.count - 1 : 0;
                    end
                    4: r.count = min_i(ld, last);
                    default: r.count = 0;
                endcase
            end
        end else if (op == 0) begin
            r.count = 0;
            r.beats = 0;
            r.run   = 0;
        end else if (m.beats == 0) begin
            r.run = 0;
            r.dn  = 1;
        end else begin
            if (wrap_en) begin
                r.count = (m.count + 1) % (last + 1);
                r.wr    = (m.count == last);
            end else r.count = min_i(m.count + 1, last);
            r.beats = m.beats - 1;
        end
        return r;
    endfunction

    function automatic logic [9:0] mdl_vec(mdl_t m, int last);
        return {5'(m.count), m.count == last, m.count == 0, m.wr, m.run, m.dn};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_a = mdl_reset();
            m_b = mdl_reset();
        end else begin
            m_a = mdl_next(m_a, 31, 1'b1, int'(opc), int'(load), start, int'(len));
            m_b = mdl_next(m_b, 20, 1'b0, int'(opc), int'(load), start, int'(len));
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        check("model_a {count,flag,zero,wrap,busy,done}",
              {cnt_a, flag_a, zero_a, wrap_a, busy_a, done_a}, mdl_vec(m_a, 31));
        check("model_b {count,flag,zero,wrap,busy,done}",
              {cnt_b, flag_b, zero_b, wrap_b, busy_b, done_b}, mdl_vec(m_b, 20));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        opc   = 3'b001;
        load  = '0;
        start = 1'b0;
        len   = '0;

        #2;
        check("reset count", cnt_a, 0);
        check("reset zero", zero_a, 1);
        check("reset flag", flag_a, 0);
        check("reset wrap", wrap_a, 0);
        check("reset busy", busy_a, 0);
        check("reset done", done_a, 0);

        @(negedge clk);
        rst_n = 1'b1;

        // 31 increments reach Last; one more wraps (A) or saturates (B).
        opc = 3'b010;
        repeat (31) tick();
        check("inc31 count_a", cnt_a, 31);
        check("inc31 flag_a", flag_a, 1);
        check("inc31 count_b", cnt_b, 20);
        check("inc31 flag_b", flag_b, 1);
        tick();
        check("wrap count_a", cnt_a, 0);
        check("wrap pulse_a", wrap_a, 1);
        check("wrap zero_a", zero_a, 1);
        check("sat count_b", cnt_b, 20);
        check("sat no wrap_b", wrap_b, 0);
        opc = 3'b001;
        tick();
        check("wrap single cycle_a", wrap_a, 0);

        // Saturating instance: load 19 then three increments.
        opc  = 3'b100;
        load = 5'd19;
        tick();
        check("load19 count_b", cnt_b, 19);
        opc = 3'b010;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("sat inc count_b", cnt_b, 20);
            check("sat inc wrap_b", wrap_b, 0);
        end
        opc = 3'b000;
        tick();
        opc = 3'b011;
        tick();
        check("dec at 0 count_b", cnt_b, 0);
        check("dec at 0 wrap_b", wrap_b, 0);
        check("dec at 0 count_a", cnt_a, 31);
        check("dec at 0 wrap_a", wrap_a, 1);

        // Burst 29,30,31,0,1 on the wrapping instance.
        opc   = 3'b001;
        load  = 5'd29;
        len   = 5'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            logic [4:0] exp_addr;
            if (i > 0) tick();
            exp_addr = 5'(29 + i);
            check("burst count_a", cnt_a, exp_addr);
            check("burst busy_a", busy_a, 1);
            check("burst wrap_a", wrap_a, (i == 3) ? 1 : 0);
            check("burst done_a", done_a, 0);
        end
        // New start on the completing cycle is ignored.
        start = 1'b1;
        load  = 5'd3;
        len   = 5'd0;
        tick();
        check("complete count held_a", cnt_a, 1);
        check("complete busy_a", busy_a, 0);
        check("complete done_a", done_a, 1);
        tick();
        start = 1'b0;
        check("restart count_a", cnt_a, 3);
        check("restart busy_a", busy_a, 1);
        check("restart done_a", done_a, 0);
        tick();
        check("len0 done_a", done_a, 1);
        check("len0 busy_a", busy_a, 0);
        tick();
        check("done single cycle_a", done_a, 0);

        // Abort on the third beat of a long burst.
        load  = 5'd5;
        len   = 5'd10;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("beat3 count_a", cnt_a, 7);
        opc = 3'b000;
        tick();
        opc = 3'b001;
        check("abort count_a", cnt_a, 0);
        check("abort busy_a", busy_a, 0);
        check("abort done_a", done_a, 0);
        tick();
        check("abort no done_a", done_a, 0);

        // Asynchronous reset between clock edges during a burst.
        load  = 5'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst count_a", cnt_a, 0);
        check("async rst busy_a", busy_a, 0);
        check("async rst zero_a", zero_a, 1);
        check("async rst busy_b", busy_b, 0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        opc   = 3'b100;
        load  = 5'd31;
        tick();
        check("load31 count_a", cnt_a, 31);
        check("load31 clamp count_b", cnt_b, 20);
        load = 5'd25;
        tick();
        check("load25 count_a", cnt_a, 25);
        check("load25 clamp count_b", cnt_b, 20);

        // Randomised traffic checked by the model.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 8)       opc = 3'b000;
            else if (r < 40) opc = 3'b010;
            else if (r < 55) opc = 3'b011;
            else if (r < 70) opc = 3'b100;
            else if (r < 85) opc = 3'b001;
            else             opc = 3'($urandom_range(5, 7));
            load  = 5'($urandom);
            len   = 5'($urandom_range(0, 12));
            start = ($urandom_range(0, 9) == 0);
            tick();
            if ($urandom_range(0, 499) == 0) begin
                #2;
                rst_n = 1'b0;
                @(negedge clk);
                #1;
                rst_n = 1'b1;
            end
        end

        opc   = 3'b001;
        start = 1'b0;
        tick();
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
